instr_mem_loader: RTL

Program loader that writes the instruction memory read by the fetch stage. It consumes a byte stream from the debug UART receiver, assembles 32-bit big-endian instruction words and writes them to consecutive word addresses of the instruction RAM's write port. While loading, it holds the pipeline (fetch PC and IF/ID register frozen). On completion it pulses a CPU reset so fetch restarts at PC 0 on the new program.

---
 rtl/instr_mem_loader_pkg.sv | 15 +
 rtl/instr_mem_loader_byte_packer.sv | 53 +++++
 rtl/instr_mem_loader.sv | 108 ++++++++++
 3 files changed

// File: rtl/instr_mem_loader_pkg.sv
// rtl/instr_mem_loader_pkg.sv - shared constants for the instruction memory loader
package instr_mem_loader_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR_HI = 3'd1;
  localparam logic [2:0] S_HDR_LO = 3'd2;
  localparam logic [2:0] S_LOAD   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  localparam int LDR_HDR_W          = 16;
  localparam int LDR_NB_BYTE        = 8;
  localparam int LDR_BYTES_PER_WORD = 32 / LDR_NB_BYTE;

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// rtl/instr_mem_loader_byte_packer.sv - assembles big-endian words from a byte stream
module instr_mem_loader_byte_packer
  import instr_mem_loader_pkg::*;
#(
  parameter int NB_BITS = 32,
  parameter int NB_BYTE = LDR_NB_BYTE
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic               i_byte_valid,
  input  logic [NB_BYTE-1:0] i_byte,
  output logic [NB_BITS-1:0] o_word,
  output logic               o_word_valid
);

  localparam logic [1:0] LAST_BYTE = 2'(LDR_BYTES_PER_WORD - 1);

  logic [1:0]         r_cnt;
  logic [NB_BITS-1:0] r_shift;
  logic [NB_BITS-1:0] r_word;
  logic               r_word_valid;
  logic [NB_BITS-1:0] w_next_shift;

  assign w_next_shift = {r_shift[NB_BITS-NB_BYTE-1:0], i_byte};

  // Word output is registered so it lines up with the write-port timing one cycle after the last byte.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt        <= 2'd0;
      r_shift      <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_clear) begin
        r_cnt   <= 2'd0;
        r_shift <= '0;
      end else if (i_byte_valid) begin
        r_shift <= w_next_shift;
        r_cnt   <= r_cnt + 2'd1;
        if (r_cnt == LAST_BYTE) begin
          r_word       <= w_next_shift;
          r_word_valid <= 1'b1;
        end
      end
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - UART-fed program loader for the instruction RAM
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int NB_BITS   = 32,
  parameter int RAM_DEPTH = 10,
  parameter int NB_BYTE   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [NB_BYTE-1:0]   i_rx_data,
  input  logic                 i_rx_valid,
  output logic [RAM_DEPTH-1:0] o_mem_addr,
  output logic [NB_BITS-1:0]   o_mem_data,
  output logic                 o_mem_we,
  output logic                 o_cpu_hold,
  output logic                 o_cpu_rst,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic [RAM_DEPTH:0]   o_word_count
);

  localparam logic [31:0] CAPACITY = 32'd1 << RAM_DEPTH;

  logic [2:0]           r_state;
  logic [LDR_HDR_W-1:0] r_hdr;
  logic [RAM_DEPTH:0]   r_word_count;

  logic                 w_start_accept;
  logic [LDR_HDR_W-1:0] w_hdr_full;
  logic                 w_last_word;
  logic                 w_word_valid;
  logic [NB_BITS-1:0]   w_word;

  assign w_start_accept = i_start && ((r_state == S_IDLE) || (r_state == S_ERROR));
  assign w_hdr_full     = {r_hdr[LDR_HDR_W-1:NB_BYTE], i_rx_data};
  assign w_last_word    = (32'(r_word_count) + 32'd1) == 32'(r_hdr);

  instr_mem_loader_byte_packer #(
    .NB_BITS (NB_BITS),
    .NB_BYTE (NB_BYTE)
  ) u_packer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (w_start_accept),
    .i_byte_valid (i_rx_valid && (r_state == S_LOAD)),
    .i_byte       (i_rx_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_hdr        <= '0;
      r_word_count <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_ERROR: begin
          if (w_start_accept) begin
            r_state      <= S_HDR_HI;
            r_word_count <= '0;
          end
        end
        S_HDR_HI: begin
          if (i_rx_valid) begin
            r_hdr[LDR_HDR_W-1:NB_BYTE] <= i_rx_data;
            r_state                    <= S_HDR_LO;
          end
        end
        S_HDR_LO: begin
          if (i_rx_valid) begin
            r_hdr <= w_hdr_full;
            if (w_hdr_full == '0)
              r_state <= S_FINISH;
            else if (32'(w_hdr_full) > CAPACITY)
              r_state <= S_ERROR;
            else
              r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          // Count advances after the write cycle, so the address seen during the write is the old count.
          if (w_word_valid) begin
            r_word_count <= r_word_count + 1'b1;
            if (w_last_word)
              r_state <= S_FINISH;
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_we     = w_word_valid;
  assign o_mem_data   = w_word;
  assign o_mem_addr   = r_word_count[RAM_DEPTH-1:0];
  assign o_word_count = r_word_count;
  assign o_cpu_hold   = (r_state != S_IDLE);
  assign o_busy       = (r_state != S_IDLE) && (r_state != S_ERROR);
  assign o_error      = (r_state == S_ERROR);
  assign o_done       = (r_state == S_FINISH);
  assign o_cpu_rst    = (r_state == S_FINISH);

endmodule
